// File: rtl/fwnoc_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwnoc_fifo_pkg
// Description : Width helpers and parameter legality checks for the NoC FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fwnoc_fifo_pkg;

    // Pointer width carries one extra wrap bit above the storage index
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwnoc_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fwnoc_fifo_mem
// Description : DEPTH x WIDTH register array, one sync write, one async read.
// Revision    : 1.0 - initial release
// ============================================================================
module fwnoc_fifo_mem
    import fwnoc_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            wr_en,
    input  logic [fifo_ptr_w(DEPTH)-2:0]    wr_addr,
    input  logic [WIDTH-1:0]                wr_dat,
    input  logic [fifo_ptr_w(DEPTH)-2:0]    rd_addr,
    output logic [WIDTH-1:0]                rd_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/fwnoc_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : fwnoc_fifo_param
// Description : Parametrised ready/valid FIFO with occupancy count, almost-full
//               flag and synchronous flush. Define FWNOC_FIFO_BYPASS_EN for a
//               zero-latency pass-through when the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fwnoc_fifo_param
    import fwnoc_fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [WIDTH-1:0]                i_dat,
    input  logic                            i_valid,
    output logic                            i_ready,
    output logic [WIDTH-1:0]                e_dat,
    output logic                            e_valid,
    input  logic                            e_ready,
    output logic [fifo_cnt_w(DEPTH)-1:0]    count,
    output logic                            almost_full
);

    localparam int c_PTR_W = fifo_ptr_w(DEPTH);
    localparam int c_IDX_W = c_PTR_W - 1;
    localparam int c_CNT_W = fifo_cnt_w(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF_CNT = c_CNT_W'(AF_THRESH);
    localparam bit c_PARAMS_OK = is_pow2(DEPTH) && (WIDTH >= 1) &&
                                 (AF_THRESH >= 1) && (AF_THRESH <= DEPTH);

    generate
        if (!c_PARAMS_OK) begin : g_param_check
            $error("fwnoc_fifo_param: DEPTH must be a power of two >= 2 and AF_THRESH in 1..DEPTH");
        end
    endgenerate

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   w_rd_dat;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_wr_en;
    logic               w_rd_adv;

    // Wrap bit separates full (indices equal, wrap differs) from empty
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_IDX_W-1:0] == r_rd_ptr[c_IDX_W-1:0]) &&
                     (r_wr_ptr[c_IDX_W] != r_rd_ptr[c_IDX_W]);

    assign i_ready = !flush && !w_full;
    assign w_push  = i_valid && i_ready;
    assign w_pop   = e_valid && e_ready;

`ifdef FWNOC_FIFO_BYPASS_EN
    logic w_through;

    assign e_valid   = !flush && (w_empty ? i_valid : 1'b1);
    assign e_dat     = w_empty ? i_dat : w_rd_dat;
    // A word consumed in the cycle it arrives at an empty FIFO is never stored
    assign w_through = w_empty && w_push && e_ready;
    assign w_wr_en   = w_push && !w_through;
    assign w_rd_adv  = w_pop && !w_through;
`else
    assign e_valid  = !flush && !w_empty;
    assign e_dat    = w_rd_dat;
    assign w_wr_en  = w_push;
    assign w_rd_adv = w_pop;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_en && !w_rd_adv) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_en && w_rd_adv) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign count       = r_count;
    assign almost_full = (r_count >= c_AF_CNT);

    fwnoc_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (w_wr_en),
        .wr_addr (r_wr_ptr[c_IDX_W-1:0]),
        .wr_dat  (i_dat),
        .rd_addr (r_rd_ptr[c_IDX_W-1:0]),
        .rd_dat  (w_rd_dat)
    );

endmodule
`default_nettype wire
